// File: rtl/detect_sched.sv
// rtl/detect_sched.sv - two-requester frame scheduler with embedded repeat-bit detector
//
// Purpose: grants one of two requesters, clears an embedded detector, captures
// FRAME_LEN serial bits from the granted requester and counts bits that repeat
// the previous bit of the same frame. It reports the result with a done pulse,
// or pulses abort when the owner drops its request mid-frame.
//
// Optional feature macro: FIXED_PRIO_EN (requester 0 always wins; no pointer).
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   req[1:0]   - per-requester frame request, held until done or abort
//   w0, w1     - serial data bits from requester 0 / 1
//   gnt[1:0]   - one-hot grant, 00 when no owner
//   busy       - high in every state except IDLE
//   done       - one-cycle frame-finished pulse
//   done_id    - requester of the last finished frame
//   match_cnt  - repeat count of the last finished frame
//   abort      - one-cycle pulse when the owner dropped req mid-frame

module detect_sched #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       w0,
    input  logic       w1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [3:0] match_cnt,
    output logic       abort
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        CLEAR = 4'b0010,
        RUN   = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       owner_q, owner_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       prev_q, prev_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       done_id_q, done_id_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic       abort_q, abort_d;

    logic       winner;
    logic       cur_bit;
    logic       owner_req;
    logic       is_match;
    logic [3:0] cnt_next;

`ifdef FIXED_PRIO_EN
    // Requester 0 wins any tie; requester 1 only wins when alone.
    assign winner = ~req[0];
`else
    // Round-robin: last_q holds the requester of the last completed frame.
    logic last_q, last_d;
    assign winner = (req == 2'b11) ? ~last_q : req[1];
`endif

    assign cur_bit   = owner_q ? w1 : w0;
    assign owner_req = req[owner_q];
    // Bit 0 of a frame has no predecessor, so it can never match.
    assign is_match  = (bit_cnt_q != 4'd0) && (cur_bit == prev_q);
    assign cnt_next  = run_cnt_q + {3'b000, is_match};

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        bit_cnt_d   = bit_cnt_q;
        run_cnt_d   = run_cnt_q;
        prev_d      = prev_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        abort_d     = 1'b0;
`ifndef FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = CLEAR;
                    owner_d = winner;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                end else begin
                    state_d   = RUN;
                    bit_cnt_d = 4'd0;
                    run_cnt_d = 4'd0;
                    prev_d    = 1'b0;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                end else begin
                    prev_d    = cur_bit;
                    run_cnt_d = cnt_next;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d     = DONE;
                        gnt_d       = 2'b00;
                        done_d      = 1'b1;
                        done_id_d   = owner_q;
                        match_cnt_d = cnt_next;
`ifndef FIXED_PRIO_EN
                        last_d      = owner_q;
`endif
                    end
                end
            end
            DONE: begin
                // Requests seen here are ignored; arbitration restarts in IDLE.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            owner_q     <= 1'b0;
            bit_cnt_q   <= 4'd0;
            run_cnt_q   <= 4'd0;
            prev_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            match_cnt_q <= 4'd0;
            abort_q     <= 1'b0;
`ifndef FIXED_PRIO_EN
            // "Last granted = 1" makes requester 0 win the first tie.
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            bit_cnt_q   <= bit_cnt_d;
            run_cnt_q   <= run_cnt_d;
            prev_q      <= prev_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
            abort_q     <= abort_d;
`ifndef FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;
    assign abort     = abort_q;

endmodule
